// File: rtl/rename_reg_file_pkg.sv
// rename_reg_file_pkg: shared widths and boolean constants for the rename register file.
package rename_reg_file_pkg;
   localparam int REG_IDX_W    = 5;
   localparam int DATA_WIDTH   = 32;
   localparam int ROB_ID_WIDTH = 4;
   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
endpackage

// File: rtl/rename_reg_file_rf_read_port.sv
// rf_read_port: one combinational source-operand lookup with same-cycle commit bypass.
module rf_read_port
   import rename_reg_file_pkg::*;
#(
   parameter int DW = DATA_WIDTH,
   parameter int RW = ROB_ID_WIDTH
) (
   input  logic [REG_IDX_W-1:0] idx_i,
   input  logic [DW-1:0]        value_i,
   input  logic                 busy_i,
   input  logic [RW-1:0]        tag_i,
   input  logic                 commit_valid_i,
   input  logic [REG_IDX_W-1:0] commit_rd_i,
   input  logic [RW-1:0]        commit_rob_id_i,
   input  logic [DW-1:0]        commit_value_i,
   output logic [DW-1:0]        value_o,
   output logic                 busy_o,
   output logic [RW-1:0]        rob_id_o
);
   logic zero, hit;
   always_comb begin
      zero     = (idx_i == '0);
      hit      = busy_i && commit_valid_i && (commit_rd_i == idx_i) && (commit_rob_id_i == tag_i);
      value_o  = zero ? '0 : hit ? commit_value_i : value_i;
      busy_o   = zero ? FALSE : busy_i && !hit;
      rob_id_o = busy_o ? tag_i : '0;
   end
endmodule

// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural registers with busy/ROB-tag rename status,
// in-order commit writeback, dispatch renaming and rollback flush.
module rename_reg_file
   import rename_reg_file_pkg::*;
#(
   parameter int REG_NUM = 32,
   parameter int DW      = DATA_WIDTH,
   parameter int RW      = ROB_ID_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic [REG_IDX_W-1:0] ID_rs1,
   input  logic [REG_IDX_W-1:0] ID_rs2,
   input  logic                 ID_rename_valid,
   input  logic [REG_IDX_W-1:0] ID_rd,
   input  logic [RW-1:0]        ID_rob_id,
   input  logic                 ROB_commit_valid,
   input  logic [REG_IDX_W-1:0] ROB_commit_rd,
   input  logic [RW-1:0]        ROB_commit_rob_id,
   input  logic [DW-1:0]        ROB_commit_value,
   input  logic                 ROB_roll_back_flag,
   output logic [DW-1:0]        ID_rs1_value,
   output logic                 ID_rs1_busy,
   output logic [RW-1:0]        ID_rs1_rob_id,
   output logic [DW-1:0]        ID_rs2_value,
   output logic                 ID_rs2_busy,
   output logic [RW-1:0]        ID_rs2_rob_id
);
   logic [DW-1:0]      value_q [REG_NUM];
   logic [DW-1:0]      value_d [REG_NUM];
   logic [RW-1:0]      tag_q   [REG_NUM];
   logic [RW-1:0]      tag_d   [REG_NUM];
   logic [REG_NUM-1:0] busy_q, busy_d;

   // Rename is applied after commit so it wins the status of a shared rd.
   always_comb begin
      value_d = value_q;
      tag_d   = tag_q;
      busy_d  = busy_q;
      if (rdy) begin
         if (ROB_commit_valid && ROB_commit_rd != '0) begin
            value_d[ROB_commit_rd] = ROB_commit_value;
            if (tag_q[ROB_commit_rd] == ROB_commit_rob_id) busy_d[ROB_commit_rd] = FALSE;
         end
         if (ROB_roll_back_flag) begin
            busy_d = '0;
            for (int i = 0; i < REG_NUM; i++) tag_d[i] = '0;
         end else if (ID_rename_valid && ID_rd != '0) begin
            busy_d[ID_rd] = TRUE;
            tag_d[ID_rd]  = ID_rob_id;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
      end else begin
         busy_q  <= busy_d;
         value_q <= value_d;
         tag_q   <= tag_d;
      end
   end

   rf_read_port #(.DW(DW), .RW(RW)) u_rs1 (
      .idx_i(ID_rs1), .value_i(value_q[ID_rs1]), .busy_i(busy_q[ID_rs1]), .tag_i(tag_q[ID_rs1]),
      .commit_valid_i(ROB_commit_valid), .commit_rd_i(ROB_commit_rd),
      .commit_rob_id_i(ROB_commit_rob_id), .commit_value_i(ROB_commit_value),
      .value_o(ID_rs1_value), .busy_o(ID_rs1_busy), .rob_id_o(ID_rs1_rob_id)
   );

   rf_read_port #(.DW(DW), .RW(RW)) u_rs2 (
      .idx_i(ID_rs2), .value_i(value_q[ID_rs2]), .busy_i(busy_q[ID_rs2]), .tag_i(tag_q[ID_rs2]),
      .commit_valid_i(ROB_commit_valid), .commit_rd_i(ROB_commit_rd),
      .commit_rob_id_i(ROB_commit_rob_id), .commit_value_i(ROB_commit_value),
      .value_o(ID_rs2_value), .busy_o(ID_rs2_busy), .rob_id_o(ID_rs2_rob_id)
   );
endmodule
